// File: rtl/memory_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : memory_arbiter
// Purpose  : two-requester round-robin arbiter for a single memory port,
//            with bounded lock ownership for atomic sequences.
// Revision : 1.0
// ---------------------------------------------------------------------------
module memory_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_LIMIT = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  lock_timeout
);

  localparam int CNT_WIDTH = $clog2(LOCK_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_limit = CNT_WIDTH'(LOCK_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_next;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  r_last_grant;
  logic                  r_lock_timeout;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [DATA_WIDTH-1:0] r_wdata_hold;
  logic [DATA_WIDTH-1:0] r_rdata0_hold;
  logic [DATA_WIDTH-1:0] r_rdata1_hold;
  logic                  w_req0_q;
  logic                  w_req1_q;
  logic                  w_ack0;
  logic                  w_ack1;
  logic                  w_forced;

  // Reset kills grants immediately so nothing is issued while reset is low.
  assign w_req0_q  = req0 & reset_n;
  assign w_req1_q  = req1 & reset_n;
  assign w_cnt_inc = r_cnt + c_cnt_one;

  always_comb begin
    w_ack0       = 1'b0;
    w_ack1       = 1'b0;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_forced     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req0_q && w_req1_q) begin
          w_ack0 = r_last_grant;
          w_ack1 = ~r_last_grant;
        end else begin
          w_ack0 = w_req0_q;
          w_ack1 = w_req1_q;
        end
        // The acquiring cycle already counts as the first held cycle.
        if (w_ack0 && lock0) begin
          if (LOCK_LIMIT > 1) begin
            w_state_next = ST_OWN0;
            w_cnt_next   = c_cnt_one;
          end else begin
            w_forced = 1'b1;
          end
        end else if (w_ack1 && lock1) begin
          if (LOCK_LIMIT > 1) begin
            w_state_next = ST_OWN1;
            w_cnt_next   = c_cnt_one;
          end else begin
            w_forced = 1'b1;
          end
        end
      end
      ST_OWN0: begin
        w_ack0 = w_req0_q;
        if (!lock0) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (w_cnt_inc >= c_cnt_limit) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_forced     = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      ST_OWN1: begin
        w_ack1 = w_req1_q;
        if (!lock1) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (w_cnt_inc >= c_cnt_limit) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_forced     = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_last_grant   <= 1'b1;
      r_lock_timeout <= 1'b0;
      r_rvalid0      <= 1'b0;
      r_rvalid1      <= 1'b0;
      r_addr_hold    <= '0;
      r_wdata_hold   <= '0;
      r_rdata0_hold  <= '0;
      r_rdata1_hold  <= '0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_lock_timeout <= w_forced;
      r_rvalid0      <= w_ack0;
      r_rvalid1      <= w_ack1;
      if (w_ack0) begin
        r_last_grant <= 1'b0;
        r_addr_hold  <= addr0;
        r_wdata_hold <= wdata0;
      end else if (w_ack1) begin
        r_last_grant <= 1'b1;
        r_addr_hold  <= addr1;
        r_wdata_hold <= wdata1;
      end
      if (r_rvalid0) r_rdata0_hold <= mem_read_data;
      if (r_rvalid1) r_rdata1_hold <= mem_read_data;
    end
  end

  // Memory returns data one cycle after the address, so rdata is passed
  // straight through while rvalid is high and held otherwise.
  assign ack0             = w_ack0;
  assign ack1             = w_ack1;
  assign rvalid0          = r_rvalid0;
  assign rvalid1          = r_rvalid1;
  assign rdata0           = r_rvalid0 ? mem_read_data : r_rdata0_hold;
  assign rdata1           = r_rvalid1 ? mem_read_data : r_rdata1_hold;
  assign mem_address      = w_ack0 ? addr0  : (w_ack1 ? addr1  : r_addr_hold);
  assign mem_write_data   = w_ack0 ? wdata0 : (w_ack1 ? wdata1 : r_wdata_hold);
  assign mem_write_enable = (w_ack0 & we0) | (w_ack1 & we1);
  assign lock_timeout     = r_lock_timeout;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_memory_arbiter
// Purpose  : directed and randomized self-checking bench for memory_arbiter.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LL = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_enable;
  logic [DW-1:0] mem_read_data = '0;
  logic          lock_timeout;

  logic [DW-1:0] mem [0:4095];

  int n_tests = 0;
  int n_fail  = 0;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_LIMIT(LL)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .ack0(ack0), .ack1(ack1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
    .lock_timeout(lock_timeout)
  );

  always #5 clock = ~clock;

  // Synchronous memory: one-cycle read latency, write-through on writes.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] <= 16'(i) ^ 16'h5A5A;
    mem[12'h010] <= 16'hBEEF;
    mem[12'h020] <= 16'h1111;
    mem[12'h030] <= 16'h2222;
  end

  always @(posedge clock) begin
    if (mem_write_enable) mem[mem_address[11:0]] <= mem_write_data;
    mem_read_data <= mem_write_enable ? mem_write_data : mem[mem_address[11:0]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_in();
    reset_n = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
  endtask

  int exp_w [4];
  logic prev_ack0, prev_ack1;
  logic [DW-1:0] exp_d0, exp_d1;
  int err_both, err_noreq, err_rv, err_rd, wait0, wait1, max_wait0, max_wait1, total_acks;

  initial begin
    idle_in();
    reset_n = 0;
    req0 = 1; we0 = 1; addr0 = 16'h0055; wdata0 = 16'hAAAA;
    #2;
    check_eq("rst_ack0", ack0, 0);
    check_eq("rst_we", mem_write_enable, 0);
    check_eq("rst_addr", mem_address, 0);
    check_eq("rst_wdata", mem_write_data, 0);
    check_eq("rst_rvalid0", rvalid0, 0);
    check_eq("rst_rdata0", rdata0, 0);
    check_eq("rst_timeout", lock_timeout, 0);

    // Single read of 0x0010.
    do_reset();
    req0 = 1; addr0 = 16'h0010;
    #1;
    check_eq("rd_ack0", ack0, 1);
    check_eq("rd_ack1", ack1, 0);
    check_eq("rd_addr", mem_address, 16'h0010);
    check_eq("rd_we", mem_write_enable, 0);
    @(negedge clock); idle_in(); #1;
    check_eq("rd_rvalid0", rvalid0, 1);
    check_eq("rd_rdata0", rdata0, 16'hBEEF);
    check_eq("rd_rvalid1", rvalid1, 0);
    @(negedge clock); #1;
    check_eq("rd_rvalid0_low", rvalid0, 0);
    check_eq("rd_rdata0_hold", rdata0, 16'hBEEF);

    // Round-robin tie for four cycles.
    do_reset();
    exp_w[0] = 0; exp_w[1] = 1; exp_w[2] = 0; exp_w[3] = 1;
    for (int k = 0; k < 4; k++) begin
      req0 = 1; addr0 = 16'h0020; req1 = 1; addr1 = 16'h0030;
      #1;
      check_eq("rr_ack0", ack0, exp_w[k] == 0);
      check_eq("rr_ack1", ack1, exp_w[k] == 1);
      check_eq("rr_addr", mem_address, exp_w[k] == 0 ? 16'h0020 : 16'h0030);
      if (k > 0) begin
        check_eq("rr_rvalid", exp_w[k-1] == 0 ? rvalid0 : rvalid1, 1);
        check_eq("rr_rdata", exp_w[k-1] == 0 ? rdata0 : rdata1,
                 exp_w[k-1] == 0 ? 16'h1111 : 16'h2222);
      end
      @(negedge clock);
    end
    idle_in(); #1;
    check_eq("rr_last_rvalid1", rvalid1, 1);
    check_eq("rr_last_rdata1", rdata1, 16'h2222);

    // Locked write by requester 1 while requester 0 waits.
    do_reset();
    req1 = 1; we1 = 1; addr1 = 16'h0100; wdata1 = 16'h1234; lock1 = 1;
    #1;
    check_eq("lk_c1_ack1", ack1, 1);
    check_eq("lk_c1_we", mem_write_enable, 1);
    check_eq("lk_c1_addr", mem_address, 16'h0100);
    check_eq("lk_c1_wdata", mem_write_data, 16'h1234);
    @(negedge clock);
    req0 = 1; addr0 = 16'h0020;
    #1;
    check_eq("lk_c2_ack1", ack1, 1);
    check_eq("lk_c2_ack0", ack0, 0);
    check_eq("lk_c2_rvalid1", rvalid1, 1);
    check_eq("lk_c2_rdata1", rdata1, 16'h1234);
    @(negedge clock);
    lock1 = 0;
    #1;
    check_eq("lk_c3_ack1", ack1, 1);
    check_eq("lk_c3_ack0", ack0, 0);
    @(negedge clock);
    req1 = 0; we1 = 0;
    #1;
    check_eq("lk_c4_ack0", ack0, 1);
    check_eq("lk_c4_addr", mem_address, 16'h0020);
    @(negedge clock);
    idle_in(); #1;
    check_eq("lk_c5_rvalid0", rvalid0, 1);
    check_eq("lk_c5_rdata0", rdata0, 16'h1111);

    // Lock held past LOCK_LIMIT is forcibly released.
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 16'h0020; req1 = 1; addr1 = 16'h0030;
    #1;
    check_eq("to_c1_ack0", ack0, 1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clock); #1;
      check_eq("to_hold_ack0", ack0, 1);
      check_eq("to_hold_ack1", ack1, 0);
      check_eq("to_hold_timeout", lock_timeout, 0);
    end
    @(negedge clock); #1;
    check_eq("to_c5_ack1", ack1, 1);
    check_eq("to_c5_ack0", ack0, 0);
    check_eq("to_c5_timeout", lock_timeout, 1);
    @(negedge clock);
    idle_in(); #1;
    check_eq("to_c6_timeout", lock_timeout, 0);
    check_eq("to_c6_rvalid1", rvalid1, 1);
    check_eq("to_c6_rdata1", rdata1, 16'h2222);

    // Reset asserted in the middle of an acked read.
    do_reset();
    req0 = 1; addr0 = 16'h0020; req1 = 1; addr1 = 16'h0030;
    #1;
    check_eq("mr_ack0_pre", ack0, 1);
    reset_n = 0;
    #1;
    check_eq("mr_ack0_in_rst", ack0, 0);
    check_eq("mr_addr_in_rst", mem_address, 0);
    @(negedge clock);
    idle_in();
    reset_n = 1;
    #1;
    check_eq("mr_rvalid0", rvalid0, 0);
    check_eq("mr_rvalid1", rvalid1, 0);
    @(negedge clock);
    req0 = 1; addr0 = 16'h0020; req1 = 1; addr1 = 16'h0030;
    #1;
    check_eq("mr_rvalid0_later", rvalid0, 0);
    check_eq("mr_first_tie", ack0, 1);
    @(negedge clock);
    idle_in();

    // Random traffic: mutual exclusion, completions, fairness.
    do_reset();
    prev_ack0 = 0; prev_ack1 = 0; exp_d0 = '0; exp_d1 = '0;
    err_both = 0; err_noreq = 0; err_rv = 0; err_rd = 0;
    wait0 = 0; wait1 = 0; max_wait0 = 0; max_wait1 = 0; total_acks = 0;
    for (int n = 0; n < 10000; n++) begin
      if (rvalid0 !== prev_ack0 || rvalid1 !== prev_ack1) err_rv++;
      if (rvalid0 && rdata0 !== exp_d0) err_rd++;
      if (rvalid1 && rdata1 !== exp_d1) err_rd++;
      req0   = ($urandom_range(0, 3) != 0);
      req1   = ($urandom_range(0, 3) != 0);
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      lock0  = ($urandom_range(0, 2) != 0);
      lock1  = ($urandom_range(0, 2) != 0);
      addr0  = 16'($urandom_range(0, 63));
      addr1  = 16'($urandom_range(0, 63));
      wdata0 = 16'($urandom);
      wdata1 = 16'($urandom);
      #1;
      if (ack0 && ack1) err_both++;
      if ((ack0 && !req0) || (ack1 && !req1)) err_noreq++;
      if (ack0) exp_d0 = we0 ? wdata0 : mem[addr0[11:0]];
      if (ack1) exp_d1 = we1 ? wdata1 : mem[addr1[11:0]];
      prev_ack0 = ack0;
      prev_ack1 = ack1;
      if (ack0 || ack1) total_acks++;
      wait0 = (req0 && !ack0) ? wait0 + 1 : 0;
      wait1 = (req1 && !ack1) ? wait1 + 1 : 0;
      if (wait0 > max_wait0) max_wait0 = wait0;
      if (wait1 > max_wait1) max_wait1 = wait1;
      @(negedge clock);
    end
    check_eq("rand_both_ack", err_both, 0);
    check_eq("rand_ack_no_req", err_noreq, 0);
    check_eq("rand_rvalid", err_rv, 0);
    check_eq("rand_rdata", err_rd, 0);
    check_eq("rand_starve0", max_wait0 > LL + 1, 0);
    check_eq("rand_starve1", max_wait1 > LL + 1, 0);
    check_eq("rand_activity", total_acks > 5000, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, word-address width of the shared memory port.
REQ-002 Parameter DATA_WIDTH, default 16, data word width.
REQ-003 Parameter LOCK_LIMIT, default 16, maximum consecutive cycles one requester may hold a lock.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req0, req1  input  1 each  access request from requester 0 (CPU) and requester 1 (I/O/DMA).
REQ-007 we0, we1  input  1 each  1 = write, 0 = read, qualified by reqN.
REQ-008 addr0, addr1  input  ADDR_WIDTH each  word address.
REQ-009 wdata0, wdata1  input  DATA_WIDTH each  write data.
REQ-010 lock0, lock1  input  1 each  hold ownership after the current access (atomic sequence).
REQ-011 ack0, ack1  output  1 each  access accepted this cycle (combinational).
REQ-012 rvalid0, rvalid1  output  1 each  registered; rdataN valid this cycle.
REQ-013 rdata0, rdata1  output  DATA_WIDTH each  read/write-through data returned by memory.
REQ-014 mem_address  output  ADDR_WIDTH  to the memory port address.
REQ-015 mem_write_data  output  DATA_WIDTH  to the memory port write data.
REQ-016 mem_write_enable  output  1  to the memory port write enable.
REQ-017 mem_read_data  input  DATA_WIDTH  memory output, registered one cycle after address; on a write it equals the written data.
REQ-018 lock_timeout  output  1  registered; one-cycle pulse when a lock is forcibly released.

Function
REQ-019 At most one ackN SHALL be high in any cycle; ackN high implies reqN high.
REQ-020 Memory outputs SHALL mux from the acked requester; with no ack, mem_write_enable = 0 and address/data hold the last granted values.
REQ-021 States: IDLE, OWN0, OWN1; IDLE arbitrates, OWNn grants only requester n.
REQ-022 IDLE, one request: that requester acked.
REQ-023 IDLE, both requesting: round-robin; winner is the requester not granted most recently (pointer last_grant).
REQ-024 last_grant SHALL update to the acked requester on every ack.
REQ-025 Ack to n with lockN high: next state OWNn, lock counter loaded to 1.
REQ-026 In OWNn: reqN acked regardless of the other requester; counter increments each cycle.
REQ-027 OWNn exits to IDLE when lockN is low, or when the counter reaches LOCK_LIMIT (forced release).
REQ-028 Forced release: lock_timeout pulses the following cycle, last_grant = n, and the other requester wins the next tie.
REQ-029 Exit from OWNn SHALL take effect next cycle; the cycle lockN drops, reqN is still served if asserted.
REQ-030 Read latency: ackN in cycle T -> rvalidN high in cycle T+1 with rdataN = mem_read_data.
REQ-031 Writes SHALL also raise rvalidN at T+1 (write-through data), giving a uniform completion.
REQ-032 rdataN SHALL hold its last value when rvalidN is low; a one-bit tag per requester tracks in-flight ownership.
REQ-033 Back-to-back acks to alternating requesters SHALL sustain one access per cycle, no bubbles.
REQ-034 reqN dropping without ack SHALL leave no state change; reqN with lockN but no ack SHALL not enter OWNn.

Reset
REQ-035 reset_n low SHALL immediately force: state IDLE, last_grant = 1, lock counter 0, rvalid0/1 = 0, rdata0/1 = 0, lock_timeout = 0, mem_write_enable = 0, mem_address = 0, mem_write_data = 0, ack0/1 = 0.
REQ-036 An access acked in the cycle reset asserts SHALL NOT produce an rvalid after reset release.
REQ-037 First tie after reset release SHALL go to requester 0.

Verification
REQ-038 Reset, then req0 read addr 0x0010 (memory holds 0xBEEF) -> ack0 same cycle, rvalid0 next cycle, rdata0 = 0xBEEF.
REQ-039 req0 and req1 asserted together for 4 cycles -> acks 0,1,0,1; mem_address alternates addr0/addr1; rvalid follows each ack by 1 cycle.
REQ-040 req1 write 0x1234 to 0x0100 with lock1 for 3 cycles, req0 held -> ack1 for 3 cycles, ack0 only after lock1 drops; rdata1 = 0x1234.
REQ-041 LOCK_LIMIT = 4, lock0 held continuously, req1 waiting -> ack0 4 cycles, lock_timeout pulse, next cycle ack1.
REQ-042 reset_n pulsed low during an acked read -> rvalid0/1 stay 0 after release; first tie goes to requester 0.
REQ-043 Random req/we/lock stimulus, 10k cycles -> never both acks high, every ack has exactly one matching rvalid one cycle later, no requester starved beyond LOCK_LIMIT+1 cycles.
